// File: rtl/vc_read_arbiter_pkg.sv
// Shared types and constants for the VC read arbiter and its priority selector.
package vc_read_arbiter_pkg;
  typedef enum logic [1:0] {
    RESET  = 2'd0,
    INIT   = 2'd1,
    IDLE   = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  localparam logic SRC_VC0 = 1'b0;
  localparam logic SRC_VC1 = 1'b1;
  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int CNT_W  = 4;
  localparam int STAGES = 2;
endpackage

// File: rtl/vc_read_arbiter_prio_sel.sv
// VC0-priority grant logic with a burst counter that guarantees VC1 one grant
// after MAXBURST consecutive VC0 grants while VC1 is waiting.
module vc_prio_sel
  import vc_read_arbiter_pkg::*;
#(
  parameter int MAXBURST = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic active,
  input  logic pause,
  input  logic vc0_empty,
  input  logic vc1_empty,
  output logic vc0_rd,
  output logic vc1_rd
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAXBURST);

  logic [CNT_W-1:0] burst_cnt;
  logic             vc1_turn;
  logic             issue;

  assign vc1_turn = (burst_cnt == MAX_CNT) & ~vc1_empty;
  assign issue    = active & ~pause;
  assign vc0_rd   = issue & ~vc0_empty & ~vc1_turn;
  assign vc1_rd   = issue & ~vc1_empty & (vc0_empty | vc1_turn);

  // Only counts VC0 grants that actually made VC1 wait.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                        burst_cnt <= '0;
    else if (vc1_rd || vc1_empty)        burst_cnt <= '0;
    else if (vc0_rd && burst_cnt != MAX_CNT) burst_cnt <= burst_cnt + 1'b1;
  end
endmodule

// File: rtl/vc_read_arbiter.sv
// Read engine for VC0/VC1 FIFOs: arbitrates pops, then routes each word by its
// destination bit into D0 or D1 two cycles after the pop.
module vc_read_arbiter
  import vc_read_arbiter_pkg::*;
#(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int MAXBURST = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_pause,
  input  logic          D1_pause,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic          D0_push,
  output logic [BW-1:0] D0_data_in,
  output logic          D1_push,
  output logic [BW-1:0] D1_data_in,
  output logic          idle
);
  state_e            state, state_nxt;
  logic [STAGES:1]   vld_pipe;
  logic              src_q;
  logic              pipe_busy;
  logic [BW-1:0]     word;

  assign pipe_busy = |vld_pipe;

  vc_prio_sel #(.MAXBURST(MAXBURST)) u_prio_sel (
    .clk       (clk),
    .reset_L   (reset_L),
    .active    (state == ACTIVE),
    .pause     (D0_pause | D1_pause),
    .vc0_empty (VC0_empty),
    .vc1_empty (VC1_empty),
    .vc0_rd    (VC0_rd),
    .vc1_rd    (VC1_rd)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= RESET;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   state_nxt = INIT;
      INIT:    state_nxt = IDLE;
      IDLE:    if (!VC0_empty || !VC1_empty) state_nxt = ACTIVE;
      ACTIVE:  if (VC0_empty && VC1_empty && !pipe_busy) state_nxt = IDLE;
      default: state_nxt = RESET;
    endcase
  end

  assign idle = (state == IDLE) & VC0_empty & VC1_empty & ~pipe_busy;

  // FIFO read data arrives one cycle after the pop; src_q picks which bus.
  assign word = (src_q == SRC_VC1) ? VC1_data_out : VC0_data_out;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_pipe   <= '0;
      src_q      <= SRC_VC0;
      D0_push    <= 1'b0;
      D1_push    <= 1'b0;
      D0_data_in <= '0;
      D1_data_in <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], VC0_rd | VC1_rd};
      src_q    <= VC1_rd ? SRC_VC1 : SRC_VC0;
      D0_push  <= vld_pipe[1] & (word[DEST_BIT] == DEST_D0);
      D1_push  <= vld_pipe[1] & (word[DEST_BIT] == DEST_D1);
      if (vld_pipe[1]) begin
        if (word[DEST_BIT] == DEST_D1) D1_data_in <= word;
        else                           D0_data_in <= word;
      end
    end
  end
endmodule

// File: tb/tb_vc_read_arbiter.sv
// Bench for vc_read_arbiter: FIFO models feed the DUT, a scoreboard predicts
// every push at pop time, and a scenario table checks grant ordering.
module tb_vc_read_arbiter;
  localparam int BW = 6, DEST_BIT = 4, MAXBURST = 4;

  logic clk = 1'b0, reset_L = 1'b0;
  logic VC0_empty, VC1_empty;
  logic [BW-1:0] VC0_data_out = '0, VC1_data_out = '0;
  logic D0_pause = 1'b0, D1_pause = 1'b0;
  logic VC0_rd, VC1_rd, D0_push, D1_push, idle;
  logic [BW-1:0] D0_data_in, D1_data_in;

  vc_read_arbiter #(.BW(BW), .DEST_BIT(DEST_BIT), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset_L(reset_L), .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data_out(VC0_data_out), .VC1_data_out(VC1_data_out),
    .D0_pause(D0_pause), .D1_pause(D1_pause), .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
    .D0_push(D0_push), .D0_data_in(D0_data_in), .D1_push(D1_push),
    .D1_data_in(D1_data_in), .idle(idle));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO models: data valid the cycle after the pop.
  logic [BW-1:0] vc0_mem [64];
  logic [BW-1:0] vc1_mem [64];
  int vc0_rp = 0, vc0_wp = 0, vc1_rp = 0, vc1_wp = 0;
  assign VC0_empty = (vc0_rp == vc0_wp);
  assign VC1_empty = (vc1_rp == vc1_wp);
  always @(posedge clk) begin
    if (VC0_rd) begin VC0_data_out <= vc0_mem[vc0_rp % 64]; vc0_rp <= vc0_rp + 1; end
    if (VC1_rd) begin VC1_data_out <= vc1_mem[vc1_rp % 64]; vc1_rp <= vc1_rp + 1; end
  end

  int pass_cnt = 0, total = 0, bad_pop = 0, push_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct { logic dest; logic [BW-1:0] data; int due; } push_t;
  push_t sb[$];
  logic glog[$];
  logic [BW-1:0] d0_log[$], d1_log[$];

  task automatic check_push(input logic dest, input logic [BW-1:0] data);
    push_t e;
    push_cnt++;
    if (dest) d1_log.push_back(data); else d0_log.push_back(data);
    if (sb.size() == 0) begin
      total++;
      $display("FAIL unexpected_push: dest %0d data %0h at cycle %0d", dest, data, cyc);
    end else begin
      e = sb.pop_front();
      chk("push_dest", 32'(dest), 32'(e.dest));
      chk("push_data", 32'(data), 32'(e.data));
      chk("push_cycle", 32'(cyc), 32'(e.due));
    end
  endtask

  always @(negedge clk) begin
    logic [BW-1:0] w;
    if (reset_L) begin
      if ((VC0_rd && VC0_empty) || (VC1_rd && VC1_empty) || (VC0_rd && VC1_rd)) bad_pop++;
      if (VC0_rd) begin
        w = vc0_mem[vc0_rp % 64];
        sb.push_back('{w[DEST_BIT], w, cyc + 2}); glog.push_back(1'b0);
      end
      if (VC1_rd) begin
        w = vc1_mem[vc1_rp % 64];
        sb.push_back('{w[DEST_BIT], w, cyc + 2}); glog.push_back(1'b1);
      end
      if (D0_push) check_push(1'b0, D0_data_in);
      if (D1_push) check_push(1'b1, D1_data_in);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        total++;
        $display("FAIL push_missing: data %0h due %0d not pushed by %0d", sb[0].data, sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic src, input logic [BW-1:0] w);
    if (src) begin vc1_mem[vc1_wp % 64] = w; vc1_wp++; end
    else     begin vc0_mem[vc0_wp % 64] = w; vc0_wp++; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin tick(); n++; end while (!idle && n < budget);
    chk({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  function automatic string glog_str();
    string s = "";
    foreach (glog[i]) s = {s, glog[i] ? "1" : "0"};
    return s;
  endfunction

  typedef struct { int n0; int n1; string exp; } scen_t;
  scen_t scen [6];

  initial begin
    string s;
    int g0, p0, n;
    scen[0] = '{3, 0, "000"};
    scen[1] = '{10, 10, "00001000010011111111"};
    scen[2] = '{0, 3, "111"};
    scen[3] = '{6, 1, "0000100"};
    scen[4] = '{2, 2, "0011"};
    scen[5] = '{5, 3, "00001011"};

    // Reset state, then both VCs stay empty.
    repeat (3) tick();
    chk("rst_vc0_rd", 32'(VC0_rd), 0); chk("rst_vc1_rd", 32'(VC1_rd), 0);
    chk("rst_d0_push", 32'(D0_push), 0); chk("rst_d1_push", 32'(D1_push), 0);
    chk("rst_d0_data", 32'(D0_data_in), 0); chk("rst_d1_data", 32'(D1_data_in), 0);
    chk("rst_idle", 32'(idle), 0);
    reset_L = 1'b1;
    tick();
    chk("init_idle", 32'(idle), 0);
    tick();
    chk("idle_2nd_cycle", 32'(idle), 1);
    repeat (5) tick();
    chk("empty_no_reads", 32'(glog.size()), 0);

    // Three D0 words from VC0 alone.
    load(0, 6'h01); load(0, 6'h02); load(0, 6'h03);
    wait_idle("three_words", 50);
    chk("three_d0_cnt", 32'(d0_log.size()), 3);
    if (d0_log.size() == 3) begin
      chk("three_d0_w0", 32'(d0_log[0]), 32'h01);
      chk("three_d0_w1", 32'(d0_log[1]), 32'h02);
      chk("three_d0_w2", 32'(d0_log[2]), 32'h03);
    end
    s = glog_str(); total++;
    if (s == "000") pass_cnt++; else $display("FAIL three_grants: got %s expected 000", s);

    // Mixed destinations.
    d0_log.delete(); d1_log.delete();
    load(0, 6'h00); load(0, 6'h10); load(0, 6'h05); load(0, 6'h1F);
    wait_idle("mixed", 50);
    chk("mixed_d0_cnt", 32'(d0_log.size()), 2);
    chk("mixed_d1_cnt", 32'(d1_log.size()), 2);
    if (d0_log.size() == 2 && d1_log.size() == 2) begin
      chk("mixed_d0_a", 32'(d0_log[0]), 32'h00); chk("mixed_d0_b", 32'(d0_log[1]), 32'h05);
      chk("mixed_d1_a", 32'(d1_log[0]), 32'h10); chk("mixed_d1_b", 32'(d1_log[1]), 32'h1F);
    end

    // Grant-ordering scenarios; both VCs loaded in the same cycle.
    for (int k = 0; k < 6; k++) begin
      glog.delete();
      for (int i = 0; i < scen[k].n0; i++) load(0, BW'($urandom_range(0, 63)));
      for (int i = 0; i < scen[k].n1; i++) load(1, BW'($urandom_range(0, 63)));
      wait_idle($sformatf("scen%0d", k), 200);
      s = glog_str(); total++;
      if (s == scen[k].exp) pass_cnt++;
      else $display("FAIL scen%0d_grants: got %s expected %s", k, s, scen[k].exp);
    end

    // Pause while streaming: in-flight words still land, reads stop at once.
    for (int i = 0; i < 8; i++) load(0, BW'(i * 9));
    repeat (3) tick();
    D1_pause = 1'b1; #1;
    chk("pause_rd_same_cycle", 32'(VC0_rd), 0);
    g0 = glog.size(); p0 = push_cnt;
    repeat (4) tick();
    chk("pause_inflight_pushes", 32'(push_cnt - p0), 2);
    chk("pause_no_grants", 32'(glog.size() - g0), 0);
    D1_pause = 1'b0; #1;
    chk("pause_resume_rd", 32'(VC0_rd), 1);
    wait_idle("pause", 50);

    // Reset with two words in flight.
    for (int i = 0; i < 8; i++) load(0, BW'(6'h11 + i));
    repeat (4) tick();
    chk("inflight_before_reset", 32'(sb.size()), 2);
    reset_L = 1'b0; #1;
    sb.delete();
    chk("mid_rst_rd", 32'({VC0_rd, VC1_rd}), 0);
    chk("mid_rst_push", 32'({D0_push, D1_push}), 0);
    chk("mid_rst_data", 32'({D0_data_in, D1_data_in}), 0);
    tick();
    reset_L = 1'b1;
    tick();
    chk("post_rst_init_rd", 32'(VC0_rd), 0);
    chk("post_rst_init_idle", 32'(idle), 0);
    n = 1;
    while (!VC0_rd && n < 10) begin tick(); n++; end
    chk("post_rst_first_read_edge", 32'(n), 3);
    wait_idle("post_rst", 60);

    chk("no_bad_pops", 32'(bad_pop), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/vc_read_arbiter.md
Name: vc_read_arbiter

Overview:
- Read-side engine for the virtual-channel FIFOs (VC0 high priority, VC1 low priority).
- Pops words from the two VC FIFOs under a priority policy with starvation protection.
- Routes each popped word by its destination bit to the D0 or D1 downstream FIFO.
- Stops issuing reads while either downstream FIFO asserts pause (its almost_full).

Parameters:
- BW, 6, data width in bits.
- DEST_BIT, 4, bit index of a word that selects the destination: 0 goes to D0, 1 goes to D1.
- MAXBURST, 4, maximum consecutive VC0 grants while VC1 is non-empty before VC1 receives one grant. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- VC0_empty  in  1  VC0 FIFO empty flag.
- VC1_empty  in  1  VC1 FIFO empty flag.
- VC0_data_out  in  BW  VC0 FIFO read data, valid the cycle after VC0_rd.
- VC1_data_out  in  BW  VC1 FIFO read data, valid the cycle after VC1_rd.
- D0_pause  in  1  D0 FIFO almost_full.
- D1_pause  in  1  D1 FIFO almost_full.
- VC0_rd  out  1  pop strobe to VC0.
- VC1_rd  out  1  pop strobe to VC1.
- D0_push  out  1  write strobe to D0.
- D0_data_in  out  BW  write data to D0.
- D1_push  out  1  write strobe to D1.
- D1_data_in  out  BW  write data to D1.
- idle  out  1  both VCs empty and no word in flight.

Behaviour:
- Async reset (reset_L=0):
  - State goes to RESET; burst counter and all pipeline registers clear to 0.
  - Outputs: VC0_rd=0, VC1_rd=0, D0_push=0, D1_push=0, D0_data_in=0, D1_data_in=0, idle=0.
- States:
  - RESET: on reset_L high, go to INIT.
  - INIT: one cycle, no reads issued; go to IDLE.
  - IDLE: if !VC0_empty or !VC1_empty, go to ACTIVE.
  - ACTIVE: if both VCs are empty and the pipeline is empty, go to IDLE.
- Read strobes are combinational from registered state plus inputs. Define pause = D0_pause | D1_pause.
  - VC0_rd = ACTIVE & !pause & !VC0_empty & !(VC1 turn).
  - VC1_rd = ACTIVE & !pause & !VC1_empty & (VC0_empty | VC1 turn).
  - VC1 turn = (burst_cnt == MAXBURST) & !VC1_empty.
  - At most one read strobe is high per cycle.
- Burst counter (4 bits):
  - Increments on each VC0_rd while VC1 is non-empty, saturating at MAXBURST.
  - Clears on VC1_rd, and clears while VC1_empty=1.
- Pipeline (latency 2: read at cycle N, push at cycle N+2):
  - Cycle N: rd is asserted; a 1-bit source tag is registered.
  - Cycle N+1: FIFO data is valid; at the end of N+1 the selected word is registered into D0_data_in or D1_data_in according to word[DEST_BIT].
  - Cycle N+2: the matching D0_push or D1_push is high for exactly one cycle.
  - The unselected data output holds its previous value.
- Throughput: one word per cycle when unpaused.
- Pause:
  - Takes effect combinationally in the same cycle; no new read is issued.
  - Words already in flight (up to 2) still complete their push.
  - Downstream almost_full thresholds must leave at least 2 free slots.
- idle = (state==IDLE) & VC0_empty & VC1_empty & no word in flight. It is 0 in RESET and INIT.
- Empty mid-stream: an empty VC is simply not read; the pipeline drains normally.
- Both VCs become non-empty in the same cycle: VC0 wins unless it is VC1's turn.
- Reset asserted mid-transfer: in-flight words are discarded and all outputs return to their reset values immediately.
- No pop is ever issued to an empty FIFO.

Decomposition:
- Shared package holds:
  - state encodings RESET, INIT, IDLE, ACTIVE;
  - source tag constants SRC_VC0=0, SRC_VC1=1;
  - destination constants DEST_D0=0, DEST_D1=1.
- One natural sub-module: vc_prio_sel. It contains the grant logic and the burst counter, and produces VC0_rd and VC1_rd.
- The FSM, pipeline and router stay in the top module.

Test Plan:
- Reset, then VC0 holds 3 words with DEST bit 0 and VC1 is empty:
  - VC0_rd is high for 3 consecutive cycles;
  - D0_push is high 2 cycles later with the words in order;
  - idle=1 after drain.
- VC0 and VC1 each hold 10 words, MAXBURST=4:
  - grant pattern is VC0×4, VC1×1, repeating;
  - once VC0 is empty, the remaining VC1 words flow back-to-back.
- Mixed destinations, words 6'h00, 6'h10, 6'h05, 6'h1F from VC0:
  - D0 receives 6'h00 and 6'h05;
  - D1 receives 6'h10 and 6'h1F;
  - each push occurs exactly 2 cycles after its read.
- D1_pause raised while streaming:
  - reads stop the same cycle;
  - exactly the in-flight words (at most 2) are still pushed;
  - reads resume the cycle after pause drops.
- reset_L dropped with 2 words in flight:
  - all pushes and reads are 0 immediately, data outputs are 0;
  - after release, one INIT cycle precedes the first read.
- Both VCs always empty:
  - VC0_rd and VC1_rd never assert;
  - idle=1 from the second cycle after reset release.
